// File: rtl/branch_pkg.sv
// Shared types and constants for the branch controller: opcodes, FSM states,
// PC width and the constant table of 9-bit relative branch offsets.
package branch_pkg;

    localparam int PC_W      = 9;
    localparam int LUT_MAX_W = 5;

    typedef enum logic [2:0] {
        OP_NONE = 3'b000,
        OP_BRZ  = 3'b001,
        OP_BRNZ = 3'b010,
        OP_JMP  = 3'b011,
        OP_CALL = 3'b100,
        OP_RET  = 3'b101
    } branch_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_DONE
    } fsm_state_t;

    // Two's-complement offsets; fetch adds them to the PC with 9-bit wrap.
    localparam logic [PC_W-1:0] LUT_OFFSETS [2**LUT_MAX_W] = '{
        9'h002, 9'h01E, 9'h1FC, 9'h006, 9'h1FF, 9'h064, 9'h19C, 9'h0FF,
        9'h100, 9'h010, 9'h1F0, 9'h020, 9'h1E0, 9'h001, 9'h003, 9'h1FD,
        9'h040, 9'h1C0, 9'h008, 9'h1F8, 9'h00C, 9'h1F4, 9'h018, 9'h1E8,
        9'h030, 9'h1D0, 9'h005, 9'h1FB, 9'h07F, 9'h181, 9'h011, 9'h000
    };

    function automatic logic [PC_W-1:0] lut_offset(input logic [LUT_MAX_W-1:0] idx);
        return LUT_OFFSETS[idx];
    endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch-side bus of branch_ctrl: decode/ALU/fetch inputs and the fetch
// control outputs (Start, CMP_Flag, Target) plus run status.
interface branch_ctrl_if #(
    parameter int LUT_W = 5
);
    import branch_pkg::*;

    logic              Req;
    logic              Halt;
    logic [2:0]        BranchOp;
    logic [LUT_W-1:0]  LutIdx;
    logic              Zero;
    logic [PC_W-1:0]   ProgCtr;
    logic              Start;
    logic              CMP_Flag;
    logic [PC_W-1:0]   Target;
    logic              Done;
    logic              StackErr;

    modport master (
        output Req, Halt, BranchOp, LutIdx, Zero, ProgCtr,
        input  Start, CMP_Flag, Target, Done, StackErr
    );

    modport slave (
        input  Req, Halt, BranchOp, LutIdx, Zero, ProgCtr,
        output Start, CMP_Flag, Target, Done, StackErr
    );

endinterface

// File: rtl/ret_stack.sv
// Return-address stack of D 9-bit entries for gosub/return; top is the most
// recent push. Push when full and pop when empty are ignored.
module ret_stack
    import branch_pkg::*;
#(
    parameter int D = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clr,
    input  logic            i_push,
    input  logic            i_pop,
    input  logic [PC_W-1:0] i_data,
    output logic [PC_W-1:0] o_top,
    output logic            o_full,
    output logic            o_empty
);

    localparam int              PW     = $clog2(D);
    localparam logic [PW:0]     P_FULL = (PW + 1)'(D);

    logic [PC_W-1:0] r_mem [D];
    logic [PW:0]     r_ptr;
    logic [PW-1:0]   w_top_idx;

    assign o_full    = (r_ptr == P_FULL);
    assign o_empty   = (r_ptr == '0);
    assign w_top_idx = PW'(r_ptr - 1'b1);
    assign o_top     = r_mem[w_top_idx];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ptr <= '0;
        end else if (i_clr) begin
            r_ptr <= '0;
        end else if (i_push && !o_full) begin
            r_ptr <= r_ptr + 1'b1;
        end else if (i_pop && !o_empty) begin
            r_ptr <= r_ptr - 1'b1;
        end
    end

    // NOTE: storage has no reset; the pointer alone decides which entries are valid.
    always_ff @(posedge i_clk) begin
        if (i_push && !o_full && !i_clr) begin
            r_mem[r_ptr[PW-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/branch_ctrl.sv
// Program-flow controller: run sequencing FSM, LUT-based branch resolution
// and, when BRANCH_CALL_STACK_EN is defined, gosub/return via ret_stack.
module branch_ctrl
    import branch_pkg::*;
#(
    parameter int D     = 4,
    parameter int LUT_W = 5
) (
    input  logic         Clk,
    input  logic         Reset,
    branch_ctrl_if.slave bus
);

    if ((D < 2) || (D > 16) || ((D & (D - 1)) != 0)) begin : g_bad_depth
        $error("branch_ctrl: D must be a power of two in 2..16");
    end

    fsm_state_t              r_state;
    fsm_state_t              w_next_state;
    logic [LUT_MAX_W-1:0]    w_lut_idx;
    logic [PC_W-1:0]         w_lut;
    logic                    w_cmp;
    logic [PC_W-1:0]         w_target;

    assign w_lut_idx = LUT_MAX_W'(bus.LutIdx);
    assign w_lut     = lut_offset(w_lut_idx);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: default every always_comb output first so no path infers a latch.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (bus.Req)   w_next_state = S_ARMED;
            S_ARMED: if (!bus.Req)  w_next_state = S_RUN;
            S_RUN:   if (bus.Halt)  w_next_state = S_DONE;
            S_DONE:  if (bus.Req)   w_next_state = S_ARMED;
            default:                w_next_state = S_IDLE;
        endcase
    end

`ifdef BRANCH_CALL_STACK_EN
    logic            w_push;
    logic            w_pop;
    logic            w_err_set;
    logic            w_run_entry;
    logic            w_full;
    logic            w_empty;
    logic [PC_W-1:0] w_top;
    logic [PC_W-1:0] w_ret_addr;
    logic            r_stack_err;

    assign w_run_entry = (r_state == S_ARMED) && !bus.Req;
    assign w_ret_addr  = bus.ProgCtr + 9'd1;

    ret_stack #(.D(D)) u_ret_stack (
        .i_clk   (Clk),
        .i_rst_n (Reset),
        .i_clr   (w_run_entry),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_ret_addr),
        .o_top   (w_top),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_stack_err <= 1'b0;
        end else if (w_run_entry) begin
            r_stack_err <= 1'b0;
        end else if (w_err_set) begin
            r_stack_err <= 1'b1;
        end
    end

    assign bus.StackErr = r_stack_err;
`else
    assign bus.StackErr = 1'b0;
`endif

    always_comb begin
        w_cmp    = 1'b0;
        w_target = '0;
`ifdef BRANCH_CALL_STACK_EN
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
`endif
        // DONE holds the PC by taking a zero offset every cycle.
        if (r_state == S_DONE) begin
            w_cmp = 1'b1;
        end else if ((r_state == S_RUN) && !bus.Halt) begin
            case (bus.BranchOp)
                OP_BRZ: begin
                    w_cmp    = bus.Zero;
                    w_target = w_lut;
                end
                OP_BRNZ: begin
                    w_cmp    = !bus.Zero;
                    w_target = w_lut;
                end
                OP_JMP: begin
                    w_cmp    = 1'b1;
                    w_target = w_lut;
                end
`ifdef BRANCH_CALL_STACK_EN
                OP_CALL: begin
                    if (!w_full) begin
                        w_push   = 1'b1;
                        w_cmp    = 1'b1;
                        w_target = w_lut;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
                OP_RET: begin
                    if (!w_empty) begin
                        w_pop    = 1'b1;
                        w_cmp    = 1'b1;
                        w_target = w_top - bus.ProgCtr;
                    end else begin
                        w_err_set = 1'b1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign bus.Start    = (r_state == S_IDLE) || (r_state == S_ARMED);
    assign bus.Done     = (r_state == S_DONE);
    assign bus.CMP_Flag = w_cmp;
    assign bus.Target   = w_target;

endmodule
